// File: rtl/inputbuffer_bank_sched.sv
// Stream-to-bank sequencer for the 3-bank input buffer: fills the write bank, rotates banks, maps reads.
// Define INBUF_SCHED_ERR_CHK_EN to enable the sticky protocol error flag (err_flag tied 0 otherwise).
module inputbuffer_bank_sched #(
    parameter int DW         = 128,
    parameter int AW         = 10,
    parameter int BANK_DEPTH = 1024
) (
    input  logic          SYS_CLK,
    input  logic          SYS_NRST,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic          rd_req_vld,
    input  logic          rd_req_sel,
    input  logic [AW-1:0] rd_req_addr,
    input  logic          rd_release,
    output logic [1:0]    rd_bank_cnt,
    output logic [AW:0]   rd_older_len,
    output logic [AW:0]   rd_newer_len,
    output logic          rd_rsp_vld,
    output logic [DW-1:0] rd_rsp_data,
    output logic          sram_cmd_write_valid,
    output logic [DW-1:0] sram_cmd_write_data,
    output logic [AW-1:0] sram_cmd_write_addr,
    output logic          sram_cmd_read_valid,
    output logic [AW+1:0] sram_cmd_read_addr,
    input  logic          sram_rsp_read_valid,
    input  logic [DW-1:0] sram_rsp_read_data,
    output logic          sram_cmd_status_update,
    output logic          sram_cmd_start,
    output logic          sram_cmd_end,
    output logic          err_flag
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    localparam logic [AW:0] DEPTH = (AW+1)'(BANK_DEPTH);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    function automatic logic [1:0] bank_inc(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    state_t      r_state;
    logic [1:0]  r_wbank;
    logic [1:0]  r_cnt;
    logic [AW:0] r_wr_cnt;
    logic [AW:0] r_len [3];
    logic        r_eop_seen;
    logic        r_start;
    logic        r_end;
    logic        r_update;

    logic [1:0]  w_older;
    logic [1:0]  w_newer;
    logic [1:0]  w_cnt_nxt;
    logic        w_closed;
    logic        w_rel_ok;
    logic        w_rotate;
    logic        w_older_ok;
    logic        w_newer_ok;
    logic        w_sel_ok;
    logic        w_wr;

    // A closed bank waits here until a read slot is free (or freed this cycle).
    assign w_closed   = (r_state == S_FILL) && ((r_wr_cnt == DEPTH) || r_eop_seen);
    assign w_rel_ok   = rd_release && (r_cnt != 2'd0);
    assign w_rotate   = w_closed && ((r_cnt != 2'd2) || w_rel_ok);
    assign w_cnt_nxt  = r_cnt + {1'b0, w_rotate} - {1'b0, w_rel_ok};

    assign in_rdy     = (r_state == S_FILL) && !w_closed;
    assign w_wr       = in_vld && in_rdy;

    assign w_older    = bank_inc(r_wbank);
    assign w_newer    = bank_inc(w_older);
    assign w_newer_ok = (r_cnt != 2'd0);
    assign w_older_ok = (r_cnt == 2'd2);
    assign w_sel_ok   = rd_req_sel ? w_newer_ok : w_older_ok;

    assign sram_cmd_write_valid   = w_wr;
    assign sram_cmd_write_data    = in_data;
    assign sram_cmd_write_addr    = r_wr_cnt[AW-1:0];
    assign sram_cmd_read_valid    = rd_req_vld && w_sel_ok;
    assign sram_cmd_read_addr     = {(rd_req_sel ? w_newer : w_older), rd_req_addr};
    assign rd_rsp_vld             = sram_rsp_read_valid;
    assign rd_rsp_data            = sram_rsp_read_data;
    assign rd_bank_cnt            = r_cnt;
    assign rd_older_len           = w_older_ok ? r_len[w_older] : '0;
    assign rd_newer_len           = w_newer_ok ? r_len[w_newer] : '0;
    assign sram_cmd_status_update = r_update;
    assign sram_cmd_start         = r_start;
    assign sram_cmd_end           = r_end;

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            r_state    <= S_IDLE;
            r_wbank    <= 2'd0;
            r_cnt      <= 2'd0;
            r_wr_cnt   <= '0;
            r_eop_seen <= 1'b0;
            r_start    <= 1'b0;
            r_end      <= 1'b0;
            r_update   <= 1'b0;
            for (int i = 0; i < 3; i++) r_len[i] <= '0;
        end else begin
            r_start  <= 1'b0;
            r_end    <= 1'b0;
            r_update <= 1'b0;
            r_cnt    <= w_cnt_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_vld && in_sop) begin
                        r_start    <= 1'b1;
                        r_wr_cnt   <= '0;
                        r_eop_seen <= 1'b0;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_wr) begin
                        r_wr_cnt <= r_wr_cnt + ONE;
                        if (in_eop) r_eop_seen <= 1'b1;
                    end
                    if (w_rotate) begin
                        r_update       <= 1'b1;
                        r_len[r_wbank] <= r_wr_cnt;
                        r_wbank        <= bank_inc(r_wbank);
                        r_wr_cnt       <= '0;
                        r_eop_seen     <= 1'b0;
                        if (r_eop_seen) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == 2'd0) begin
                        r_end   <= 1'b1;
                        r_wbank <= 2'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef INBUF_SCHED_ERR_CHK_EN
    logic r_err;
    logic r_first;

    // r_first exempts the frame's own sop beat, which is still presented in the first S_FILL cycle.
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_first <= 1'b1;
            else if (w_wr) r_first <= 1'b0;
            if ((rd_req_vld && !w_sel_ok) || (rd_release && (r_cnt == 2'd0)) ||
                (in_vld && in_sop && (r_state == S_FILL) && !r_first))
                r_err <= 1'b1;
        end
    end
    assign err_flag = r_err;
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_inputbuffer_bank_sched.sv
// Scoreboard bench for inputbuffer_bank_sched: random frames and consumer traffic against a bank-queue model.
module tb_inputbuffer_bank_sched;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BANK_DEPTH = 32;

    logic          SYS_CLK = 1'b0;
    logic          SYS_NRST;
    logic          in_vld, in_rdy, in_sop, in_eop;
    logic [DW-1:0] in_data;
    logic          rd_req_vld, rd_req_sel, rd_release;
    logic [AW-1:0] rd_req_addr;
    logic [1:0]    rd_bank_cnt;
    logic [AW:0]   rd_older_len, rd_newer_len;
    logic          rd_rsp_vld;
    logic [DW-1:0] rd_rsp_data;
    logic          sram_cmd_write_valid;
    logic [DW-1:0] sram_cmd_write_data;
    logic [AW-1:0] sram_cmd_write_addr;
    logic          sram_cmd_read_valid;
    logic [AW+1:0] sram_cmd_read_addr;
    logic          sram_rsp_read_valid;
    logic [DW-1:0] sram_rsp_read_data;
    logic          sram_cmd_status_update, sram_cmd_start, sram_cmd_end, err_flag;

    inputbuffer_bank_sched #(.DW(DW), .AW(AW), .BANK_DEPTH(BANK_DEPTH)) dut (
        .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .rd_req_vld(rd_req_vld), .rd_req_sel(rd_req_sel), .rd_req_addr(rd_req_addr),
        .rd_release(rd_release), .rd_bank_cnt(rd_bank_cnt),
        .rd_older_len(rd_older_len), .rd_newer_len(rd_newer_len),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_data(rd_rsp_data),
        .sram_cmd_write_valid(sram_cmd_write_valid), .sram_cmd_write_data(sram_cmd_write_data),
        .sram_cmd_write_addr(sram_cmd_write_addr),
        .sram_cmd_read_valid(sram_cmd_read_valid), .sram_cmd_read_addr(sram_cmd_read_addr),
        .sram_rsp_read_valid(sram_rsp_read_valid), .sram_rsp_read_data(sram_rsp_read_data),
        .sram_cmd_status_update(sram_cmd_status_update), .sram_cmd_start(sram_cmd_start),
        .sram_cmd_end(sram_cmd_end), .err_flag(err_flag)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct { int len; int base; } bank_t;
    typedef struct { logic [DW-1:0] d; int off; } wr_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] beats[$];
    bank_t         exp_upd[$];
    bank_t         readable[$];
    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    int            n_start = 0, n_end = 0, n_frames = 0, invalid_evt = 0, acc_in_frame = 0;
    bit            mon_en = 1'b1, cons_en = 1'b0, hold = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the SRAM controller: follows the bank rotation via the command pulses.
    logic [DW-1:0] mem [0:2][0:BANK_DEPTH-1];
    logic [1:0]    emu_wb, emu_wb_eff;
    assign emu_wb_eff = sram_cmd_end ? 2'd0 :
                        sram_cmd_status_update ? ((emu_wb == 2'd2) ? 2'd0 : emu_wb + 2'd1) : emu_wb;

    always @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            emu_wb              <= 2'd0;
            sram_rsp_read_valid <= 1'b0;
            sram_rsp_read_data  <= '0;
        end else begin
            emu_wb <= emu_wb_eff;
            if (sram_cmd_write_valid)
                mem[emu_wb_eff][int'(sram_cmd_write_addr) % BANK_DEPTH] <= sram_cmd_write_data;
            sram_rsp_read_valid <= sram_cmd_read_valid;
            if (sram_cmd_read_valid)
                sram_rsp_read_data <= mem[sram_cmd_read_addr[AW+1:AW]][int'(sram_cmd_read_addr[AW-1:0]) % BANK_DEPTH];
        end
    end

    // Monitor: write commands and read responses against the scoreboard queues.
    initial forever begin
        @(negedge SYS_CLK);
        if (mon_en) begin
            if (sram_cmd_write_valid) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("write_data", sram_cmd_write_data, w.d);
                    chk("write_addr", sram_cmd_write_addr, w.off);
                end
            end
            if (rd_rsp_vld) begin
                if (exp_rd.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("read_data", rd_rsp_data, exp_rd.pop_front());
            end
        end
    end

    // Consumer + readable-bank model: banks become readable on each rotation, oldest released first.
    initial begin
        bank_t b;
        int    r, sel, off;
        bit    ok;
        forever begin
            @(negedge SYS_CLK);
            rd_req_vld = 1'b0;
            rd_release = 1'b0;
            if (mon_en) begin
                if (sram_cmd_start) n_start++;
                if (sram_cmd_status_update) begin
                    if (exp_upd.size() == 0) chk("unexpected_update", 1, 0);
                    else begin
                        b = exp_upd.pop_front();
                        chk("update_newer_len", rd_newer_len, b.len);
                        readable.push_back(b);
                    end
                end
                if (sram_cmd_end) begin
                    n_end++;
                    chk("end_with_banks_left", readable.size(), 0);
                end
                chk("rd_bank_cnt", rd_bank_cnt, readable.size());
                if (readable.size() == 2) chk("older_len", rd_older_len, readable[0].len);
                if (cons_en) begin
                    r = $urandom_range(0, 15);
                    if (r < 4 && !hold && readable.size() > 0) begin
                        rd_release = 1'b1;
                        void'(readable.pop_front());
                    end else if (r == 4 && !hold && readable.size() == 0) begin
                        rd_release = 1'b1;
                        invalid_evt++;
                    end else if (r >= 5 && r < 12) begin
                        sel = $urandom_range(0, 1);
                        ok  = (sel == 1) ? (readable.size() >= 1) : (readable.size() == 2);
                        off = $urandom_range(0, BANK_DEPTH - 1);
                        if (ok) begin
                            b   = (sel == 1) ? readable[readable.size() - 1] : readable[0];
                            off = $urandom_range(0, b.len - 1);
                            exp_rd.push_back(beats[b.base + off]);
                        end else invalid_evt++;
                        rd_req_vld  = 1'b1;
                        rd_req_sel  = sel[0];
                        rd_req_addr = AW'(off);
                        #1;
                        chk("read_valid", sram_cmd_read_valid, ok);
                        if (ok) chk("read_offset", sram_cmd_read_addr[AW-1:0], off);
                    end
                end
            end
        end
    end

    task automatic send_frame(input int n);
        int  base;
        bit  acc;
        wr_t w;
        base = beats.size();
        for (int k = 0; k < n; k++) beats.push_back($urandom);
        for (int b = 0; b * BANK_DEPTH < n; b++) begin
            bank_t bk;
            bk.len  = (n - b * BANK_DEPTH < BANK_DEPTH) ? n - b * BANK_DEPTH : BANK_DEPTH;
            bk.base = base + b * BANK_DEPTH;
            exp_upd.push_back(bk);
        end
        n_frames++;
        acc_in_frame = 0;
        for (int k = 0; k < n; k++) begin
            w.d = beats[base + k];
            w.off = k % BANK_DEPTH;
            exp_wr.push_back(w);
            in_data = w.d;
            in_sop  = (k == 0);
            in_eop  = (k == n - 1);
            do begin
                in_vld = ($urandom_range(0, 3) != 0);
                @(negedge SYS_CLK);
                acc = in_vld && in_rdy;
                @(posedge SYS_CLK);
                #1;
            end while (!acc);
            acc_in_frame++;
        end
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, n_end=%0d expected %0d", n_end, n_frames);
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[$];
        SYS_NRST = 1'b0;
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        rd_req_vld = 1'b0; rd_req_sel = 1'b0; rd_req_addr = '0; rd_release = 1'b0;
        repeat (3) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_bank_cnt", rd_bank_cnt, 0);
        chk("rst_newer_len", rd_newer_len, 0);
        chk("rst_older_len", rd_older_len, 0);
        chk("rst_pulses", {sram_cmd_status_update, sram_cmd_start, sram_cmd_end}, 0);
        chk("rst_write_valid", sram_cmd_write_valid, 0);
        chk("rst_err", err_flag, 0);
        SYS_NRST = 1'b1;
        @(posedge SYS_CLK);
        #1;

        // Beats without sop in idle are held off.
        in_vld = 1'b1;
        in_data = 32'hdead_beef;
        repeat (4) begin
            @(negedge SYS_CLK);
            chk("idle_no_sop_rdy", in_rdy, 0);
            chk("idle_no_sop_start", sram_cmd_start, 0);
        end
        @(posedge SYS_CLK);
        #1;
        in_vld = 1'b0;
        cons_en = 1'b1;

        // No releases: three banks absorb 3*DEPTH beats, then the stream stalls until a release.
        hold = 1'b1;
        fork
            send_frame(4 * BANK_DEPTH);
            begin
                for (int i = 0; i < 4000 && acc_in_frame < 3 * BANK_DEPTH; i++) @(negedge SYS_CLK);
                repeat (12) begin
                    @(negedge SYS_CLK);
                    chk("blocked_in_rdy", in_rdy, 0);
                end
                chk("blocked_accepted", acc_in_frame, 3 * BANK_DEPTH);
                hold = 1'b0;
            end
        join

        lens = '{1, 7, BANK_DEPTH, BANK_DEPTH + 1, 2 * BANK_DEPTH, 3 * BANK_DEPTH};
        repeat (6) lens.push_back($urandom_range(1, 3 * BANK_DEPTH));
        foreach (lens[i]) begin
            send_frame(lens[i]);
            repeat ($urandom_range(0, 5)) @(posedge SYS_CLK);
            #1;
        end

        for (int i = 0; i < 5000 && n_end < n_frames; i++) @(negedge SYS_CLK);
        repeat (4) @(negedge SYS_CLK);
        chk("start_count", n_start, n_frames);
        chk("end_count", n_end, n_frames);
        chk("pending_updates", exp_upd.size(), 0);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_reads", exp_rd.size(), 0);
`ifdef INBUF_SCHED_ERR_CHK_EN
        chk("err_flag", err_flag, invalid_evt > 0);
`else
        chk("err_flag", err_flag, 0);
`endif

        // Asynchronous reset in the middle of a frame that already rotated one bank.
        cons_en = 1'b0;
        @(negedge SYS_CLK);
        mon_en = 1'b0;
        @(posedge SYS_CLK);
        #1;
        in_vld = 1'b1;
        in_sop = 1'b1;
        repeat (2) @(posedge SYS_CLK);
        #1;
        in_sop = 1'b0;
        repeat (BANK_DEPTH + 8) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        chk("pre_reset_cnt", rd_bank_cnt, 1);
        #2;
        SYS_NRST = 1'b0;
        #1;
        chk("async_rst_cnt", rd_bank_cnt, 0);
        chk("async_rst_in_rdy", in_rdy, 0);
        chk("async_rst_newer_len", rd_newer_len, 0);
        chk("async_rst_write_valid", sram_cmd_write_valid, 0);
        in_vld = 1'b0;
        @(negedge SYS_CLK);
        SYS_NRST = 1'b1;
        repeat (5) begin
            @(negedge SYS_CLK);
            chk("no_end_after_reset", sram_cmd_end, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
